// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared constants for the bomb game: game FSM and countdown
//                timer state encodings (3-bit), BCD digit width and the
//                bit offsets of each digit inside the 16-bit MM:SS word.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // BCD digit geometry of the MM:SS word {min tens, min ones, sec tens, sec ones}
    localparam int c_bcd_w        = 4;
    localparam int c_sec_ones_lsb = 0;
    localparam int c_sec_tens_lsb = 4;
    localparam int c_min_ones_lsb = 8;
    localparam int c_min_tens_lsb = 12;

    // Game FSM states
    localparam logic [2:0] c_game_idle     = 3'd0;
    localparam logic [2:0] c_game_armed    = 3'd1;
    localparam logic [2:0] c_game_won      = 3'd2;
    localparam logic [2:0] c_game_exploded = 3'd3;

    // Countdown timer states
    localparam logic [2:0] c_tmr_idle      = 3'd0;
    localparam logic [2:0] c_tmr_running   = 3'd1;
    localparam logic [2:0] c_tmr_frozen    = 3'd2;
    localparam logic [2:0] c_tmr_expired   = 3'd3;

endpackage
`default_nettype wire

// File: rtl/bcd_mmss_decrement.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mmss_decrement
//  Description : Combinational MM:SS BCD minus-one with a zero flag.
//                Seconds ones wrap 0->9, seconds tens 0->5, minutes ones
//                0->9, minutes tens 0->9, each wrap borrowing from the next
//                digit up.
//  Ports       : i_value [15:0] - current MM:SS in BCD
//                o_value [15:0] - i_value minus one second
//                o_zero         - o_value is 00:00
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_mmss_decrement
    import game_pkg::*;
(
    input  logic [15:0] i_value,
    output logic [15:0] o_value,
    output logic        o_zero
);

    logic [c_bcd_w-1:0] w_so;
    logic [c_bcd_w-1:0] w_st;
    logic [c_bcd_w-1:0] w_mo;
    logic [c_bcd_w-1:0] w_mt;

    always_comb begin
        w_so = i_value[c_sec_ones_lsb +: c_bcd_w];
        w_st = i_value[c_sec_tens_lsb +: c_bcd_w];
        w_mo = i_value[c_min_ones_lsb +: c_bcd_w];
        w_mt = i_value[c_min_tens_lsb +: c_bcd_w];

        if (w_so != 4'd0) begin
            w_so = w_so - 4'd1;
        end else begin
            w_so = 4'd9;
            if (w_st != 4'd0) begin
                w_st = w_st - 4'd1;
            end else begin
                w_st = 4'd5;
                if (w_mo != 4'd0) begin
                    w_mo = w_mo - 4'd1;
                end else begin
                    w_mo = 4'd9;
                    // 00:00 is never decremented by the timer; wrap is harmless
                    w_mt = (w_mt != 4'd0) ? (w_mt - 4'd1) : 4'd9;
                end
            end
        end

        o_value = {w_mt, w_mo, w_st, w_so};
        o_zero  = (o_value == 16'h0000);
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Bomb countdown timer. A begin_timer pulse loads START_MIN:
//                START_SEC and starts a once-per-period BCD countdown; the
//                count freezes on stop_timer and raises a one-cycle
//                time_expired pulse on reaching 00:00.
//                Optional feature macro STRIKE_SPEEDUP_EN: each strike in
//                RUNNING halves the tick period (saturating at 4x speed).
//  Ports       : clock, reset (sync, active-high)
//                begin_timer, stop_timer, strike      - control inputs
//                timer_bcd[15:0]                       - MM:SS BCD
//                timer_running, tick, time_expired    - registered status
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ    = 27_000_000,
    parameter int START_MIN = 5,
    parameter int START_SEC = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_timer,
    input  logic        stop_timer,
    input  logic        strike,
    output logic [15:0] timer_bcd,
    output logic        timer_running,
    output logic        tick,
    output logic        time_expired
);

    // Prescaler only ever needs to reach CLK_HZ-1
    localparam int          c_pre_w     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [15:0] c_start_bcd = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                           4'(START_SEC / 10), 4'(START_SEC % 10)};

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [15:0]        r_bcd;
    logic [15:0]        w_bcd_nxt;
    logic [c_pre_w-1:0] r_pre;
    logic [c_pre_w-1:0] w_pre_nxt;
    logic [c_pre_w-1:0] w_limit;
    logic               r_running;
    logic               r_tick;
    logic               w_tick_nxt;
    logic               r_expired;
    logic               w_expired_nxt;
    logic               w_load;
    logic [15:0]        w_dec_value;
    logic               w_dec_zero;

`ifdef STRIKE_SPEEDUP_EN
    logic [1:0]  r_strike;
    logic [1:0]  w_strike_nxt;
    logic [31:0] w_period;

    assign w_period = 32'(CLK_HZ) >> r_strike;
    assign w_limit  = (w_period == 32'd0) ? '0 : c_pre_w'(w_period - 32'd1);
`else
    logic w_unused_strike;

    assign w_unused_strike = strike;
    assign w_limit         = c_pre_w'(CLK_HZ - 1);
`endif

    bcd_mmss_decrement u_dec (
        .i_value (r_bcd),
        .o_value (w_dec_value),
        .o_zero  (w_dec_zero)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_bcd_nxt     = r_bcd;
        w_pre_nxt     = r_pre;
        w_tick_nxt    = 1'b0;
        w_expired_nxt = 1'b0;
        w_load        = 1'b0;
`ifdef STRIKE_SPEEDUP_EN
        w_strike_nxt  = r_strike;
`endif

        case (r_state)
            c_tmr_running: begin
                // stop wins over a coincident tick: no decrement, no beep
                if (stop_timer) begin
                    w_state_nxt = c_tmr_frozen;
                end else if (r_pre >= w_limit) begin
                    w_pre_nxt  = '0;
                    w_bcd_nxt  = w_dec_value;
                    w_tick_nxt = 1'b1;
                    if (w_dec_zero) begin
                        w_state_nxt   = c_tmr_expired;
                        w_expired_nxt = 1'b1;
                    end
                end else begin
                    w_pre_nxt = r_pre + c_pre_w'(1);
                end
`ifdef STRIKE_SPEEDUP_EN
                if (strike && (r_strike != 2'd2)) begin
                    w_strike_nxt = r_strike + 2'd1;
                end
`endif
            end
            c_tmr_idle, c_tmr_frozen, c_tmr_expired: begin
                w_load = begin_timer;
            end
            default: begin
                w_state_nxt = c_tmr_idle;
            end
        endcase

        if (w_load) begin
            w_state_nxt  = c_tmr_running;
            w_bcd_nxt    = c_start_bcd;
            w_pre_nxt    = '0;
`ifdef STRIKE_SPEEDUP_EN
            w_strike_nxt = 2'd0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_tmr_idle;
            r_bcd     <= c_start_bcd;
            r_pre     <= '0;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
`ifdef STRIKE_SPEEDUP_EN
            r_strike  <= 2'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_bcd     <= w_bcd_nxt;
            r_pre     <= w_pre_nxt;
            r_running <= (w_state_nxt == c_tmr_running);
            r_tick    <= w_tick_nxt;
            r_expired <= w_expired_nxt;
`ifdef STRIKE_SPEEDUP_EN
            r_strike  <= w_strike_nxt;
`endif
        end
    end

    assign timer_bcd     = r_bcd;
    assign timer_running = r_running;
    assign tick          = r_tick;
    assign time_expired  = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer. Three instances:
//                A (CLK_HZ=4, 00:02), B (CLK_HZ=2, 10:00), C (CLK_HZ=8, 01:00).
//                Expected ticks (value and cycle) are queued when stimulus is
//                driven and popped when the DUT pulses tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic a_reset, a_begin, a_stop, a_strike, a_run, a_tick, a_exp;
    logic b_reset, b_begin, b_stop, b_strike, b_run, b_tick, b_exp;
    logic c_reset, c_begin, c_stop, c_strike, c_run, c_tick, c_exp;
    logic [15:0] a_bcd, b_bcd, c_bcd;

    countdown_timer #(.CLK_HZ(4), .START_MIN(0), .START_SEC(2)) u_dut_a (
        .clock(clock), .reset(a_reset), .begin_timer(a_begin), .stop_timer(a_stop),
        .strike(a_strike), .timer_bcd(a_bcd), .timer_running(a_run), .tick(a_tick),
        .time_expired(a_exp));

    countdown_timer #(.CLK_HZ(2), .START_MIN(10), .START_SEC(0)) u_dut_b (
        .clock(clock), .reset(b_reset), .begin_timer(b_begin), .stop_timer(b_stop),
        .strike(b_strike), .timer_bcd(b_bcd), .timer_running(b_run), .tick(b_tick),
        .time_expired(b_exp));

    countdown_timer #(.CLK_HZ(8), .START_MIN(1), .START_SEC(0)) u_dut_c (
        .clock(clock), .reset(c_reset), .begin_timer(c_begin), .stop_timer(c_stop),
        .strike(c_strike), .timer_bcd(c_bcd), .timer_running(c_run), .tick(c_tick),
        .time_expired(c_exp));

    typedef struct {
        logic [15:0] bcd;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] bcd, input int cyc);
        exp_t e;
        e.bcd = bcd;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    function automatic logic [18:0] obs_of(input int s);
        case (s)
            0:       return {a_bcd, a_run, a_tick, a_exp};
            1:       return {b_bcd, b_run, b_tick, b_exp};
            default: return {c_bcd, c_run, c_tick, c_exp};
        endcase
    endfunction

    // Pulse begin_timer on instance s for one cycle; returns in cycle 1
    task automatic start(input int s);
        case (s)
            0:       a_begin = 1'b1;
            1:       b_begin = 1'b1;
            default: c_begin = 1'b1;
        endcase
        step();
        a_begin = 1'b0;
        b_begin = 1'b0;
        c_begin = 1'b0;
    endtask

    // Observe cycles t0..t1 (relative to the begin pulse) of instance s.
    // Every tick is matched against the scoreboard; time_expired must be
    // high exactly in cycle exp_cyc.
    task automatic run_ticks(input int s, input string tag, input int t0, input int t1,
                             input int exp_cyc);
        logic [18:0] o;
        exp_t        e;
        for (int t = t0; t <= t1; t++) begin
            o = obs_of(s);
            chk($sformatf("%s expired c%0d", tag, t), 32'(o[0]), 32'(t == exp_cyc));
            if (o[1]) begin
                if (sb.size() == 0) begin
                    chk($sformatf("%s spurious tick c%0d", tag, t), 32'(o[1]), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("%s tick value c%0d", tag, t), 32'(o[18:3]), 32'(e.bcd));
                    chk($sformatf("%s tick cycle", tag), 32'(t), 32'(e.cyc));
                end
            end
            step();
        end
    endtask

    initial begin
        {a_reset, b_reset, c_reset} = 3'b111;
        {a_begin, a_stop, a_strike} = 3'b000;
        {b_begin, b_stop, b_strike} = 3'b000;
        {c_begin, c_stop, c_strike} = 3'b000;
        step();
        step();
        {a_reset, b_reset, c_reset} = 3'b000;
        step();

        // Reset state
        chk("A reset bcd",  32'(a_bcd), 32'h0002);
        chk("A reset run",  32'(a_run), 32'd0);
        chk("A reset tick", 32'(a_tick), 32'd0);
        chk("A reset exp",  32'(a_exp), 32'd0);
        chk("B reset bcd",  32'(b_bcd), 32'h1000);
        chk("C reset bcd",  32'(c_bcd), 32'h0100);

        // Basic run to expiry, with an ignored begin_timer in cycle 3
        start(0);
        chk("A run c1", 32'(a_run), 32'd1);
        chk("A bcd c1", 32'(a_bcd), 32'h0002);
        push(16'h0001, 5);
        push(16'h0000, 9);
        run_ticks(0, "A run1", 1, 2, 9);
        a_begin = 1'b1;
        run_ticks(0, "A run1", 3, 3, 9);
        a_begin = 1'b0;
        run_ticks(0, "A run1", 4, 8, 9);
        chk("A run c9", 32'(a_run), 32'd0);
        chk("A bcd c9", 32'(a_bcd), 32'h0000);
        run_ticks(0, "A run1", 9, 15, 9);
        chk("A sb empty run1", 32'(sb.size()), 32'd0);
        chk("A expired hold bcd", 32'(a_bcd), 32'h0000);

        // Restart from EXPIRED: identical timing
        start(0);
        chk("A restart bcd", 32'(a_bcd), 32'h0002);
        chk("A restart run", 32'(a_run), 32'd1);
        push(16'h0001, 5);
        push(16'h0000, 9);
        run_ticks(0, "A run2", 1, 8, 9);
        chk("A run2 run c9", 32'(a_run), 32'd0);
        run_ticks(0, "A run2", 9, 10, 9);
        chk("A sb empty run2", 32'(sb.size()), 32'd0);

        // Stop in the tick cycle: freeze, no decrement, no tick
        start(0);
        run_ticks(0, "A stop", 1, 3, -1);
        a_stop = 1'b1;
        run_ticks(0, "A stop", 4, 4, -1);
        a_stop = 1'b0;
        chk("A frozen bcd", 32'(a_bcd), 32'h0002);
        chk("A frozen tick", 32'(a_tick), 32'd0);
        chk("A frozen run", 32'(a_run), 32'd0);
        run_ticks(0, "A frozen", 5, 24, -1);
        chk("A frozen hold bcd", 32'(a_bcd), 32'h0002);

        // Restart from FROZEN, then reset while showing 00:01
        start(0);
        chk("A restart2 run", 32'(a_run), 32'd1);
        push(16'h0001, 5);
        run_ticks(0, "A run3", 1, 5, -1);
        chk("A run3 bcd c6", 32'(a_bcd), 32'h0001);
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        chk("A midreset bcd",  32'(a_bcd), 32'h0002);
        chk("A midreset run",  32'(a_run), 32'd0);
        chk("A midreset tick", 32'(a_tick), 32'd0);
        chk("A midreset exp",  32'(a_exp), 32'd0);
        run_ticks(0, "A idle", 0, 9, -1);
        chk("A idle bcd", 32'(a_bcd), 32'h0002);
        chk("A sb empty idle", 32'(sb.size()), 32'd0);

        // Digit borrow across minutes
        start(1);
        push(16'h0959, 3);
        push(16'h0958, 5);
        run_ticks(1, "B borrow", 1, 5, -1);
        chk("B sb empty", 32'(sb.size()), 32'd0);
        chk("B bcd c6", 32'(b_bcd), 32'h0958);

`ifdef STRIKE_SPEEDUP_EN
        // Two strikes -> period 2; third strike saturates
        start(2);
        c_strike = 1'b1;
        push(16'h0059, 4);
        push(16'h0058, 6);
        push(16'h0057, 8);
        push(16'h0056, 10);
        push(16'h0055, 12);
        run_ticks(2, "C fast", 1, 2, -1);
        c_strike = 1'b0;
        run_ticks(2, "C fast", 3, 5, -1);
        c_strike = 1'b1;
        run_ticks(2, "C fast", 6, 6, -1);
        c_strike = 1'b0;
        run_ticks(2, "C fast", 7, 12, -1);
        chk("C sb empty fast", 32'(sb.size()), 32'd0);
        c_stop = 1'b1;
        step();
        c_stop = 1'b0;
        chk("C stopped run", 32'(c_run), 32'd0);
        // Restart: strike count cleared, back to period 8
        start(2);
        chk("C restart bcd", 32'(c_bcd), 32'h0100);
        push(16'h0059, 9);
        push(16'h0058, 17);
        run_ticks(2, "C normal", 1, 17, -1);
        chk("C sb empty normal", 32'(sb.size()), 32'd0);
`else
        // Strikes ignored: period stays 8
        start(2);
        push(16'h0059, 9);
        push(16'h0058, 17);
        run_ticks(2, "C nostrike", 1, 1, -1);
        c_strike = 1'b1;
        run_ticks(2, "C nostrike", 2, 3, -1);
        c_strike = 1'b0;
        run_ticks(2, "C nostrike", 4, 17, -1);
        chk("C sb empty", 32'(sb.size()), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Bomb countdown timer driven by the game FSM. Starts on a one-cycle `begin_timer` pulse and decrements a BCD MM:SS value once per second of the 27 MHz game clock. Drives the time to the visuals block and raises a one-cycle `time_expired` pulse to the explode logic when the count reaches 00:00. Freezes when the FSM reports the game won.

## Interface
- `CLK_HZ`, default 27_000_000: clock cycles per nominal second (the tick period); the bench overrides it with a small value.
- `START_MIN`, default 5: loaded minutes, range 0..99.
- `START_SEC`, default 0: loaded seconds, range 0..59; `START_MIN*60+START_SEC` must be > 0.

- `clock` in 1: game clock, 27 MHz.
- `reset` in 1: synchronous, active-high.
- `begin_timer` in 1: one-cycle start/restart pulse from the game FSM.
- `stop_timer` in 1: level or pulse (game won); freezes the count.
- `strike` in 1: one-cycle pulse per wrong module action.
- `timer_bcd` out 16: {min tens, min ones, sec tens, sec ones}, 4 bits each, BCD.
- `timer_running` out 1: high while in RUNNING.
- `tick` out 1: one-cycle pulse on every decrement, used for the beep.
- `time_expired` out 1: one-cycle pulse when the count reaches 00:00.

## Operation
- States: IDLE, RUNNING, FROZEN, EXPIRED.
- Reset, which overrides everything:
  - state IDLE;
  - `timer_bcd` = start value;
  - prescaler 0, strike count 0;
  - `timer_running`, `tick` and `time_expired` all 0.
- IDLE: `begin_timer` reloads the start value, clears the prescaler and strike count, and enters RUNNING.
- RUNNING:
  - The prescaler counts up every cycle.
  - A tick fires in the cycle where the prescaler is ≥ period−1. The prescaler then returns to 0 and `timer_bcd` decrements on that edge.
  - Decrement rules: seconds ones 0→9 with a borrow; seconds tens 0→5 with a borrow; minutes are borrowed into the same way.
  - A decrement that produces 00:00 enters EXPIRED.
- `begin_timer` in RUNNING is ignored.
- `stop_timer` in RUNNING enters FROZEN. It wins over a simultaneous tick: no decrement and no `tick` pulse.
- FROZEN and EXPIRED hold `timer_bcd`. `begin_timer` in either state reloads and re-enters RUNNING exactly as from IDLE.
- `stop_timer` in IDLE, FROZEN or EXPIRED has no effect.
- `tick` is registered. It is high in the cycle the new `timer_bcd` value first appears, including the final 00:00.
- `time_expired` is registered. It is high only in the first EXPIRED cycle and never re-fires until the next start.
- `timer_running` equals (state == RUNNING) and is registered with the state.

## Timing
- Entry edge: the one after the `begin_timer` cycle. The prescaler is 0 in the first RUNNING cycle.
- First decrement is visible `CLK_HZ` cycles after the first RUNNING cycle; subsequent decrements follow every period.
- Example with `CLK_HZ`=4 and start 00:02, `begin_timer` in cycle 0:
  - RUNNING from cycle 1;
  - 00:01 with `tick` in cycle 5;
  - 00:00 with `tick`, `time_expired` and `timer_running`=0 in cycle 9.
- Output latency: zero combinational paths from inputs to outputs; every output is a flop.

## Configuration
- `STRIKE_SPEEDUP_EN` defined:
  - A 2-bit strike count increments on `strike` in RUNNING and saturates at 2.
  - Tick period = `CLK_HZ` >> strike count, so 1×, 2× or 4× speed.
  - The ≥ compare makes a strike mid-period fire on the next cycle when the prescaler already exceeds the new limit.
  - The strike count is cleared on reset and on every (re)start.
- `STRIKE_SPEEDUP_EN` undefined: `strike` is ignored and the period is always `CLK_HZ`.

## Structure
- Shared package `game_pkg`:
  - timer state encodings as 3-bit constants, alongside the game FSM states;
  - BCD digit width;
  - the `timer_bcd` field offsets.
- One sub-module, `bcd_mmss_decrement`: combinational MM:SS BCD minus-one with a zero flag. It is instantiated once in `countdown_timer`.

## Test plan
- Basic run and expiry: `CLK_HZ`=4, start 00:02, `begin_timer` in cycle 0 -> 00:01 with `tick` in cycle 5; 00:00 with `time_expired` in cycle 9; `time_expired` is 0 in cycle 10.
- Digit borrow: `CLK_HZ`=2, start 10:00 -> after one tick `timer_bcd`=16'h0959; after a second tick 16'h0958.
- Stop beats tick: `CLK_HZ`=4, `stop_timer` asserted in the tick cycle -> FROZEN; value unchanged; no `tick`; value held for 20 cycles.
- Restart and ignore:
  - `begin_timer` mid-RUNNING -> no effect;
  - `begin_timer` in EXPIRED -> reloads the start value and re-runs with identical timing.
- Reset mid-run: `reset` while the count shows 00:01 -> next cycle IDLE, `timer_bcd`= start value, all pulses 0.
- Speedup (`STRIKE_SPEEDUP_EN`, `CLK_HZ`=8):
  - two strikes -> ticks every 2 cycles;
  - a third strike saturates the count;
  - restart returns ticks to every 8 cycles.
